// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined operand-2 shifter.
package shift_pkg;

  // Shift-type encodings as carried on shift_type.
  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  // Special-case code resolved at decode, so the datapath only needs a small mux.
  typedef enum logic [2:0] {
    SpPass,
    SpZero,
    SpSignfill,
    SpShift,
    SpRrx,
    SpImmrot
  } special_e;

  // Effective shift amount: Rs[7:0], or the immediate masked to log2(width) bits.
  function automatic logic [7:0] eff_amount(input logic        use_rs,
                                            input logic [7:0]  rs,
                                            input logic [4:0]  shift_imm,
                                            input int unsigned width);
    logic [7:0] mask;
    mask = 8'(width - 1);
    return use_rs ? rs : ({3'b000, shift_imm} & mask);
  endfunction

endpackage

// File: rtl/shift_pipe_stage.sv
// One valid/payload pipeline register with bubble-collapsing advance logic.
module shift_pipe_stage #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_data,
  output logic              down_valid,
  input  logic              down_ready,
  output logic [DATA_W-1:0] down_data
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;

  // Stage can take a new op when empty or when its current op leaves this cycle.
  assign up_ready   = ~valid_q | down_ready;
  assign down_valid = valid_q;
  assign down_data  = data_q;

  // Valid bit: flush empties the stage, otherwise refill whenever advancing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (up_ready) begin
      valid_q <= up_valid;
    end
  end

  // Payload: only loads on a real transfer, so it holds steady while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else if (up_valid && up_ready && !flush) begin
      data_q <= up_data;
    end
  end

endmodule

// File: rtl/shift_unit_pipe.sv
// Pipelined data-processing operand-2 shifter with valid/ready handshake.
// Decode folds every corner case (amount 0, amount >= WIDTH, RRX, rotated
// immediate) into a special code plus a clamped amount; the datapath stage
// then only performs ordinary shifts by 0..WIDTH.
module shift_unit_pipe
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 1,
  parameter int unsigned TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] shift_in,
  input  logic [1:0]       shift_type,
  input  logic [4:0]       shift_imm,
  input  logic [7:0]       rs,
  input  logic             is_imm,
  input  logic             use_rs,
  input  logic             carry_in,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned L  = $clog2(WIDTH);
  localparam int unsigned AW = L + 1;  // amount field must hold WIDTH itself

  localparam logic [7:0]    AMT_MASK = 8'(WIDTH - 1);
  localparam logic [8:0]    W9       = 9'(WIDTH);
  localparam logic [AW-1:0] AMT_FULL = AW'(WIDTH);

  typedef struct packed {
    logic [WIDTH-1:0] operand;
    logic             cin;
    logic [1:0]       stype;
    special_e         special;
    logic [AW-1:0]    amt;
    logic [TAG_W-1:0] tag;
  } dec_t;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             carry;
    logic [TAG_W-1:0] tag;
  } res_t;

  localparam int unsigned DEC_W = $bits(dec_t);
  localparam int unsigned RES_W = $bits(res_t);

  dec_t       dec;
  dec_t       op;
  res_t       res;
  res_t       out_q;
  logic [7:0] n;
  logic [7:0] ror_r;
  logic [7:0] rot2;
  logic       op_valid;
  logic       op_ready;
  logic       first_ready;

  // Decode: resolve the effective amount and map every corner case to a special code.
  always_comb begin
    n           = eff_amount(use_rs, rs, shift_imm, WIDTH);
    ror_r       = n & AMT_MASK;
    rot2        = {3'b000, shift_imm[3:0], 1'b0};
    dec         = '0;
    dec.operand = shift_in;
    dec.cin     = carry_in;
    dec.stype   = shift_type;
    dec.tag     = in_tag;
    dec.special = SpPass;
    dec.amt     = '0;
    if (is_imm) begin
      dec.operand = WIDTH'(shift_in[7:0]);
      // rot==0 is a plain pass-through of imm8 with the incoming carry.
      if (shift_imm[3:0] != 4'd0) begin
        dec.special = SpImmrot;
        dec.amt     = AW'(rot2 & AMT_MASK);
      end
    end else if (n == 8'd0) begin
      // Immediate #0 encodes LSR/ASR #WIDTH and RRX; register #0 always passes.
      if (!use_rs) begin
        case (shift_type)
          SH_LSL: dec.special = SpPass;
          SH_LSR: begin
            dec.special = SpShift;
            dec.amt     = AMT_FULL;
          end
          SH_ASR:  dec.special = SpSignfill;
          default: dec.special = SpRrx;
        endcase
      end
    end else begin
      case (shift_type)
        SH_LSL, SH_LSR: begin
          if ({1'b0, n} <= W9) begin
            dec.special = SpShift;
            dec.amt     = AW'(n);
          end else begin
            dec.special = SpZero;
          end
        end
        SH_ASR: begin
          if ({1'b0, n} < W9) begin
            dec.special = SpShift;
            dec.amt     = AW'(n);
          end else begin
            dec.special = SpSignfill;
          end
        end
        default: begin
          // A multiple of WIDTH rotates by a full turn: value unchanged, carry = MSB.
          dec.special = SpShift;
          dec.amt     = (ror_r == 8'd0) ? AMT_FULL : AW'(ror_r);
        end
      endcase
    end
  end

  logic [L-1:0]             amt_m1;
  logic [AW-1:0]            amt_inv;
  logic signed [WIDTH-1:0]  sx;

  // Datapath: shift/rotate by 0..WIDTH and select the carry-out bit.
  always_comb begin
    amt_m1     = L'(op.amt - AW'(1));
    amt_inv    = AMT_FULL - op.amt;
    sx         = op.operand;
    res        = '0;
    res.tag    = op.tag;
    res.result = op.operand;
    res.carry  = op.cin;
    case (op.special)
      SpPass: begin
        res.result = op.operand;
        res.carry  = op.cin;
      end
      SpZero: begin
        res.result = '0;
        res.carry  = 1'b0;
      end
      SpSignfill: begin
        res.result = {WIDTH{op.operand[WIDTH-1]}};
        res.carry  = op.operand[WIDTH-1];
      end
      SpRrx: begin
        res.result = {op.cin, op.operand[WIDTH-1:1]};
        res.carry  = op.operand[0];
      end
      SpImmrot: begin
        res.result = (op.operand >> op.amt) | (op.operand << amt_inv);
        res.carry  = res.result[WIDTH-1];
      end
      default: begin
        // Amount is 1..WIDTH here; shifting by WIDTH yields zero for LSL/LSR.
        case (op.stype)
          SH_LSL: begin
            res.result = op.operand << op.amt;
            res.carry  = op.operand[amt_inv[L-1:0]];
          end
          SH_LSR: begin
            res.result = op.operand >> op.amt;
            res.carry  = op.operand[amt_m1];
          end
          SH_ASR: begin
            res.result = sx >>> op.amt;
            res.carry  = op.operand[amt_m1];
          end
          default: begin
            res.result = (op.operand >> op.amt) | (op.operand << amt_inv);
            res.carry  = op.operand[amt_m1];
          end
        endcase
      end
    endcase
  end

  if (STAGES == 2) begin : g_two
    logic [DEC_W-1:0] a_data;

    // Stage A holds the decoded op so decode and shift sit in separate cycles.
    shift_pipe_stage #(
      .DATA_W (DEC_W)
    ) u_stage_a (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .up_valid   (in_valid),
      .up_ready   (first_ready),
      .up_data    (dec),
      .down_valid (op_valid),
      .down_ready (op_ready),
      .down_data  (a_data)
    );

    assign op = dec_t'(a_data);
  end else begin : g_one
    assign op          = dec;
    assign op_valid    = in_valid;
    assign first_ready = op_ready;
  end

  logic [RES_W-1:0] out_data;

  // Output register: result, carry and tag are always driven from flops.
  shift_pipe_stage #(
    .DATA_W (RES_W)
  ) u_stage_out (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .up_valid   (op_valid),
    .up_ready   (op_ready),
    .up_data    (res),
    .down_valid (out_valid),
    .down_ready (out_ready),
    .down_data  (out_data)
  );

  assign out_q     = res_t'(out_data);
  assign result    = out_q.result;
  assign carry_out = out_q.carry;
  assign out_tag   = out_q.tag;

  // New ops are refused while flushing so nothing slips past the flush.
  assign in_ready = first_ready & ~flush;

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Directed-vector bench for shift_unit_pipe (WIDTH=32, STAGES=2).
module tb_shift_unit_pipe;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned TAG_W = 4;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] shift_in;
  logic [1:0]       shift_type;
  logic [4:0]       shift_imm;
  logic [7:0]       rs;
  logic             is_imm;
  logic             use_rs;
  logic             carry_in;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic [TAG_W-1:0] out_tag;

  int tests_run;
  int tests_failed;

  shift_unit_pipe #(
    .WIDTH  (WIDTH),
    .STAGES (2),
    .TAG_W  (TAG_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .shift_in   (shift_in),
    .shift_type (shift_type),
    .shift_imm  (shift_imm),
    .rs         (rs),
    .is_imm     (is_imm),
    .use_rs     (use_rs),
    .carry_in   (carry_in),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .carry_out  (carry_out),
    .out_tag    (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic set_op(input logic imm, input logic urs, input logic [1:0] typ,
                        input logic [4:0] simm, input logic [7:0] rsv,
                        input logic [31:0] x, input logic cin, input logic [3:0] tag);
    is_imm     = imm;
    use_rs     = urs;
    shift_type = typ;
    shift_imm  = simm;
    rs         = rsv;
    shift_in   = x;
    carry_in   = cin;
    in_tag     = tag;
  endtask

  // One op through an idle pipe with out_ready high; checks result, carry and tag.
  task automatic run_op(input string name, input logic imm, input logic urs,
                        input logic [1:0] typ, input logic [4:0] simm, input logic [7:0] rsv,
                        input logic [31:0] x, input logic cin, input logic [3:0] tag,
                        input logic [31:0] exp_res, input logic exp_c);
    int cnt;
    @(negedge clk);
    set_op(imm, urs, typ, simm, rsv, x, cin, tag);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    cnt = 0;
    while (!in_ready && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check_eq({name, "_valid"}, 64'(out_valid), 64'd1);
    check_eq({name, "_res"}, 64'(result), 64'(exp_res));
    check_eq({name, "_c"}, 64'(carry_out), 64'(exp_c));
    check_eq({name, "_tag"}, 64'(out_tag), 64'(tag));
  endtask

  logic [3:0]  got_tags[$];
  logic [31:0] got_res[$];
  int          seen;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    set_op(1'b0, 1'b0, 2'b00, 5'd0, 8'd0, 32'd0, 1'b0, 4'd0);
    #1;
    check_eq("reset_valid", 64'(out_valid), 64'd0);
    check_eq("reset_res", 64'(result), 64'd0);
    check_eq("reset_tag", 64'(out_tag), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_in_ready", 64'(in_ready), 64'd1);

    // name, imm, use_rs, type, shift_imm, rs, shift_in, cin, tag, exp result, exp carry
    run_op("imm_rot4",   1, 0, 2'b00, 5'd4,  8'd0,   32'h0000_00FF, 0, 4'd1, 32'hFF00_0000, 1);
    run_op("imm_rot0",   1, 0, 2'b00, 5'd0,  8'd0,   32'h0000_00FF, 1, 4'd2, 32'h0000_00FF, 1);
    run_op("imm_rot1",   1, 0, 2'b00, 5'd1,  8'd0,   32'h0000_0001, 1, 4'd3, 32'h4000_0000, 0);
    run_op("imm_ignore", 1, 1, 2'b10, 5'd15, 8'd5,   32'h0000_0080, 1, 4'd4, 32'h0000_0200, 0);
    run_op("lsr_imm0",   0, 0, 2'b01, 5'd0,  8'd0,   32'h8000_0000, 0, 4'd5, 32'h0000_0000, 1);
    run_op("asr_imm0",   0, 0, 2'b10, 5'd0,  8'd0,   32'h8000_0000, 0, 4'd6, 32'hFFFF_FFFF, 1);
    run_op("lsl_imm0",   0, 0, 2'b00, 5'd0,  8'd0,   32'h0000_ABCD, 0, 4'd7, 32'h0000_ABCD, 0);
    run_op("rrx",        0, 0, 2'b11, 5'd0,  8'd0,   32'h0000_0003, 1, 4'd8, 32'h8000_0001, 1);
    run_op("lsl_imm4",   0, 0, 2'b00, 5'd4,  8'd0,   32'h1000_000F, 0, 4'd9, 32'h0000_00F0, 1);
    run_op("lsl_rs32",   0, 1, 2'b00, 5'd0,  8'd32,  32'h0000_0001, 0, 4'hA, 32'h0000_0000, 1);
    run_op("lsl_rs33",   0, 1, 2'b00, 5'd0,  8'd33,  32'h0000_0001, 1, 4'hB, 32'h0000_0000, 0);
    run_op("ror_rs64",   0, 1, 2'b11, 5'd0,  8'd64,  32'h8000_0001, 0, 4'hC, 32'h8000_0001, 1);
    run_op("ror_rs8",    0, 1, 2'b11, 5'd0,  8'd8,   32'h0000_00A5, 0, 4'hD, 32'hA500_0000, 1);
    run_op("lsr_rs4",    0, 1, 2'b01, 5'd0,  8'd4,   32'h0000_00F8, 0, 4'hE, 32'h0000_000F, 1);
    run_op("lsr_rs32",   0, 1, 2'b01, 5'd0,  8'd32,  32'h8000_0000, 0, 4'hF, 32'h0000_0000, 1);
    run_op("asr_rs4",    0, 1, 2'b10, 5'd0,  8'd4,   32'h8000_0018, 0, 4'd1, 32'hF800_0001, 1);
    run_op("asr_rs200",  0, 1, 2'b10, 5'd0,  8'd200, 32'h4000_0000, 1, 4'd2, 32'h0000_0000, 0);
    run_op("rs0_pass",   0, 1, 2'b10, 5'd7,  8'd0,   32'h0000_1234, 1, 4'd3, 32'h0000_1234, 1);

    // Backpressure: fill both stages with out_ready low, third op must stall.
    @(negedge clk);
    out_ready = 1'b0;
    set_op(0, 0, 2'b00, 5'd1, 8'd0, 32'h10, 0, 4'd1);
    in_valid = 1'b1;
    check_eq("bp_ready1", 64'(in_ready), 64'd1);
    @(negedge clk);
    set_op(0, 0, 2'b00, 5'd1, 8'd0, 32'h20, 0, 4'd2);
    check_eq("bp_ready2", 64'(in_ready), 64'd1);
    @(negedge clk);
    set_op(0, 0, 2'b00, 5'd1, 8'd0, 32'h30, 0, 4'd3);
    check_eq("bp_full", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      check_eq("bp_stall_valid", 64'(out_valid), 64'd1);
      check_eq("bp_stall_res", 64'(result), 64'h20);
      check_eq("bp_stall_tag", 64'(out_tag), 64'd1);
      @(negedge clk);
      check_eq("bp_still_full", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", 64'(in_ready), 64'd1);
    got_tags.delete();
    got_res.delete();
    if (out_valid) begin
      got_tags.push_back(out_tag);
      got_res.push_back(result);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) begin
        got_tags.push_back(out_tag);
        got_res.push_back(result);
      end
    end
    check_eq("bp_count", 64'(got_tags.size()), 64'd3);
    for (int i = 0; i < 3 && i < got_tags.size(); i++) begin
      check_eq("bp_order_tag", 64'(got_tags[i]), 64'(i + 1));
      check_eq("bp_order_res", 64'(got_res[i]), 64'((i + 1) * 32'h20));
    end

    // Flush with two ops in flight; an op offered during flush is refused.
    @(negedge clk);
    out_ready = 1'b0;
    set_op(0, 0, 2'b00, 5'd1, 8'd0, 32'h50, 0, 4'd5);
    in_valid = 1'b1;
    @(negedge clk);
    set_op(0, 0, 2'b00, 5'd1, 8'd0, 32'h60, 0, 4'd6);
    @(negedge clk);
    check_eq("fl_pre_valid", 64'(out_valid), 64'd1);
    set_op(0, 0, 2'b00, 5'd1, 8'd0, 32'h70, 0, 4'd7);
    flush = 1'b1;
    out_ready = 1'b1;
    #1;
    check_eq("fl_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    check_eq("fl_out_valid", 64'(out_valid), 64'd0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check_eq("fl_no_ghosts", 64'(seen), 64'd0);

    // Asynchronous reset mid-stream clears outputs without waiting for a clock edge.
    @(negedge clk);
    out_ready = 1'b0;
    set_op(0, 1, 2'b00, 5'd0, 8'd4, 32'h1000_00FF, 0, 4'd9);
    in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("rst_pre_valid", 64'(out_valid), 64'd1);
    check_eq("rst_pre_res", 64'(result), 64'h0000_0FF0);
    check_eq("rst_pre_c", 64'(carry_out), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    check_eq("rst_async_valid", 64'(out_valid), 64'd0);
    check_eq("rst_async_res", 64'(result), 64'd0);
    check_eq("rst_async_c", 64'(carry_out), 64'd0);
    check_eq("rst_async_tag", 64'(out_tag), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("rst_after_valid", 64'(out_valid), 64'd0);
    check_eq("rst_after_ready", 64'(in_ready), 64'd1);

    // Pipe still works after reset.
    run_op("post_rst",   0, 1, 2'b01, 5'd0,  8'd1,   32'h0000_0003, 0, 4'd4, 32'h0000_0001, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/shift_unit_pipe.md
# shift_unit_pipe

Parametrised, pipelined successor to the combinational operand-2 shifter: it computes the data-processing shifter operand and shifter carry-out for LSL/LSR/ASR/ROR/RRX and the rotated 8-bit immediate, at width `WIDTH`. It adds a valid/ready handshake, one or two register stages, a pass-through tag, and a synchronous flush. It sits between register-read and the ALU in the execute path.

## Interface
- `WIDTH`, default 32: datapath width; power of two, 8..64.
- `STAGES`, default 1: register stages, 1 or 2. With 1, there is an output register only. With 2, a decode register is added.
- `TAG_W`, default 4: sideband tag width, carried unchanged.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous; drops all in-flight ops.
- `in_valid`  in  1  op offered.
- `in_ready`  out  1  op accepted when `in_valid & in_ready`.
- `shift_in`  in  WIDTH  Rm value, or imm8 in bits [7:0].
- `shift_type`  in  2  00 LSL, 01 LSR, 10 ASR, 11 ROR.
- `shift_imm`  in  5  immediate shift amount; in imm mode, bits [3:0] are rotate_imm.
- `rs`  in  8  register shift amount Rs[7:0].
- `is_imm`  in  1  rotated-immediate mode.
- `use_rs`  in  1  amount is taken from `rs`.
- `carry_in`  in  1  current C flag.
- `in_tag`  in  TAG_W  sideband.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts.
- `result`  out  WIDTH  shifter operand.
- `carry_out`  out  1  shifter carry-out.
- `out_tag`  out  TAG_W  tag of `result`.

## Operation
- Notation: L = log2(WIDTH); amount n = `use_rs` ? `rs` : `shift_imm[L-1:0]` (upper bits of `shift_imm` are ignored when WIDTH < 32).
- Imm mode: result = ROR(zero-extended imm8, 2·rot). carry = `carry_in` if rot==0, else result[WIDTH-1]. `shift_type`, `use_rs` and `rs` are ignored.
- Register amount, n==0, any type: result = `shift_in`, carry = `carry_in`.
- Register amount, LSL:
  - n<WIDTH: `shift_in`<<n, carry = bit[WIDTH-n].
  - n==WIDTH: 0, carry = bit0.
  - n>WIDTH: 0, carry = 0.
- Register amount, LSR:
  - n<WIDTH: `shift_in`>>n, carry = bit[n-1].
  - n==WIDTH: 0, carry = bit[WIDTH-1].
  - n>WIDTH: 0, carry = 0.
- Register amount, ASR:
  - n<WIDTH: arithmetic shift, carry = bit[n-1].
  - n>=WIDTH: all bits = sign, carry = sign.
- Register amount, ROR:
  - r = n[L-1:0].
  - r==0 (n≠0): result = `shift_in`, carry = bit[WIDTH-1].
  - otherwise: rotate right by r, carry = bit[r-1].
- Immediate amount, n==0:
  - LSL: pass-through, carry = `carry_in`.
  - LSR: treated as LSR #WIDTH.
  - ASR: treated as ASR #WIDTH.
  - ROR: RRX, result = {`carry_in`, `shift_in`[WIDTH-1:1]}, carry = bit0.
- Immediate amount, n≠0: same rules as register amount.
- Stage split when STAGES=2:
  - Stage A registers the decoded effective op: type, clamped amount, special-case code, operands, tag.
  - Stage B computes the shift and carry and registers the result.
- Each stage holds a valid bit and advances when it is empty or its downstream stage is advancing (bubble-collapsing). Ops are kept in order.
- `in_ready` = first stage empty or advancing. It is combinational from `out_ready` and the stage valid bits; it never depends on `in_valid`.
- `flush`:
  - Clears every stage valid on the next edge.
  - An op offered in the same cycle is not accepted; `in_ready` is forced low while `flush` is high.
- `rst`: all valid bits, `result`, `carry_out` and `out_tag` go to 0 immediately. An op in flight is lost.

## Timing
- Latency from accept to `out_valid` is STAGES cycles when not stalled.
- Throughput is 1 op per cycle with `out_ready` held high.
- While `out_valid & !out_ready`, `result`, `carry_out` and `out_tag` hold stable.
- Capacity is STAGES ops. Once full and stalled, `in_ready` is low.
- Simultaneous accept at the output and input: both transfers happen in the same cycle with no bubble.
- Outputs are registered. There is no combinational path from inputs to `result`.

## Structure
- Package `shift_pkg`:
  - Shift-type constants LSL/LSR/ASR/ROR.
  - Special-case decode enum: PASS, ZERO, SIGNFILL, SHIFT, RRX, IMMROT.
  - A function computing the effective amount for a given WIDTH.
- Sub-module `shift_pipe_stage`: a parametrised valid/payload register with advance logic. It is instantiated STAGES times; the decode and datapath logic sits between instances.

## Test plan
- WIDTH=32, imm mode, imm8=0xFF, rot=4 -> result 0xFF000000, carry 1. Same with rot=0 and `carry_in`=1 -> 0x000000FF, carry 1.
- Immediate LSR #0 on 0x80000000 -> 0, carry 1. Immediate ASR #0 on 0x80000000 -> 0xFFFFFFFF, carry 1.
- Register LSL with `shift_in`=1: rs=32 -> 0, carry 1. rs=33 -> 0, carry 0. Register ROR with rs=64 on 0x80000001 -> 0x80000001, carry 1.
- Immediate ROR #0 (RRX), `carry_in`=1, `shift_in`=0x3 -> 0x80000001, carry 1.
- STAGES=2 backpressure:
  - Setup: `out_ready` low, 3 back-to-back ops with tags 1, 2, 3.
  - After 2 accepts, `in_ready` goes low.
  - When `out_ready` rises, outputs appear with tags 1, 2, 3 in order, with no duplicates and values stable during the stall.
- Flush with 2 ops in flight -> `out_valid` is 0 on the next cycle and those results never appear. Async `rst` mid-stream -> all outputs 0 immediately.
